board_scanner: RTL
==================

// Module: board_scanner
// PURPOSE
//   Read-side sequencer for the 10x10 board RAM. On a start pulse it walks every
//   board word from BASE_ADDR upward, one word per 4-byte step, using the RAM
//   read port (r, address -> mem_out, one-cycle registered read). Each word is
//   presented downstream as a tagged cell (row, col, data) on a valid/ready
//   stream for the display and scoring logic. It never drives the RAM write port.
// PARAMETERS
//   BASE_ADDR  32'h1000  byte address of cell (0,0)
//   ROWS       10        board rows
//   COLS       10        board columns; cells are stored row-major
// PORTS
//   clk         in   1   system clock, rising edge
//   rst         in   1   synchronous reset, active-high
//   start       in   1   one-cycle pulse; begin a full board scan
//   busy        out  1   high from the cycle after an accepted start until done
//   done        out  1   one-cycle pulse after the last cell is accepted
//   ram_r       out  1   to RAM r
//   ram_address out  32  to RAM address
//   ram_data    in   32  from RAM mem_out
//   cell_valid  out  1   cell_* fields hold a valid cell
//   cell_ready  in   1   downstream accepts the cell when valid && ready
//   cell_data   out  32  board word for this cell
//   cell_row    out  4   row index, 0..ROWS-1
//   cell_col    out  4   column index, 0..COLS-1
//   cell_last   out  1   high with the cell at (ROWS-1, COLS-1)
// BEHAVIOUR
//   - Reset, sync on rst: state=IDLE; busy, done, ram_r, cell_valid, cell_last = 0;
//     ram_address, cell_data = 0; row/col counters = 0. rst overrides everything,
//     so a mid-scan reset drops the scan with no done pulse.
//   - FSM IDLE -> ISSUE -> CAPTURE -> PRESENT -> (ISSUE | FINISH) -> IDLE.
//   - IDLE: start=1 -> ISSUE, clear row/col. start while not IDLE is ignored.
//   - ISSUE: ram_r=1, ram_address = BASE_ADDR + ((row*COLS + col) << 2). Keep a
//     running byte offset that adds 4 per cell; do not use a multiplier.
//   - CAPTURE: ram_r=0. ram_data now holds the word read at the ISSUE edge, so
//     latch cell_data <= ram_data, copy the tags, and set cell_valid=1.
//   - PRESENT: hold cell_* stable while cell_valid && !cell_ready, with no time limit.
//     On acceptance: cell_valid=0; if last -> FINISH, else advance col (at COLS-1
//     wrap col to 0 and increment row) -> ISSUE.
//   - FINISH: done=1 for exactly one cycle, busy=0 in the same cycle -> IDLE.
//   - busy is high in ISSUE, CAPTURE and PRESENT.
//   - Timing: 3 cycles per cell with ready tied high. A full scan is 300 cycles
//     from the first ISSUE to the FINISH cycle.
//   - Address range: the first cell is at 0x1000 and the last at 0x118C. No
//     generated address reaches 0x1190 or above.
//   - ram_address keeps its last value outside ISSUE. ram_r is high only in ISSUE.
//   - cell_last = (row==ROWS-1 && col==COLS-1). It is registered with the other tags.
// TESTING
//   1 Preload cell k with 32'hA000_0000+k, start, ready=1 -> 100 cells in order;
//     cell 37 has row=3, col=7, data=32'hA000_0025; done at cycle 301 after start.
//   2 Check ram_address per ISSUE: 0x1000, 0x1004, ... 0x118C; ram_r high 1 cycle
//     each, never with an address >= 0x1190.
//   3 Drop ready low for 5 cycles while cell 12 is valid -> cell_* stay stable and
//     no new ram_r occurs; after ready returns, cell 13 follows with the correct data.
//   4 Pulse start while busy at cell 50 -> ignored; the scan completes once with
//     exactly 100 accepts and 1 done.
//   5 Assert rst during cell 60 -> next cycle busy=0, cell_valid=0, no done;
//     a new start rescans from cell (0,0).
//   6 Row wrap: the cell after (0,9) is (1,0) at address 0x1028; the last cell has
//     cell_last=1 at (9,9) and no other cell has cell_last=1.

Source files
------------

// File: rtl/board_scanner.sv
// Read-side sequencer for the board RAM: walks every cell row-major with a
// registered-read RAM port and streams (row, col, data) over valid/ready.
module board_scanner #(
  parameter logic [31:0] BASE_ADDR = 32'h1000,
  parameter int          ROWS      = 10,
  parameter int          COLS      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        ram_r,
  output logic [31:0] ram_address,
  input  logic [31:0] ram_data,
  output logic        cell_valid,
  input  logic        cell_ready,
  output logic [31:0] cell_data,
  output logic [3:0]  cell_row,
  output logic [3:0]  cell_col,
  output logic        cell_last
);

  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
  localparam logic [3:0] LAST_COL = 4'(COLS - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, PRESENT, FINISH} state_t;

  state_t     state, state_nx;
  logic [3:0] row, col;
  logic       at_last;
  logic       accept;

  assign at_last = (row == LAST_ROW) && (col == LAST_COL);
  assign accept  = cell_valid && cell_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ram_r    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:    if (start) state_nx = ISSUE;
      ISSUE: begin
        ram_r    = 1'b1;
        busy     = 1'b1;
        state_nx = CAPTURE;
      end
      CAPTURE: begin
        busy     = 1'b1;
        state_nx = PRESENT;
      end
      PRESENT: begin
        busy = 1'b1;
        if (accept) state_nx = cell_last ? FINISH : ISSUE;
      end
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ram_address doubles as the running byte offset: set on start, +4 per cell.
  always_ff @(posedge clk) begin
    if (rst) begin
      row         <= '0;
      col         <= '0;
      ram_address <= '0;
      cell_valid  <= 1'b0;
      cell_data   <= '0;
      cell_row    <= '0;
      cell_col    <= '0;
      cell_last   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          row         <= '0;
          col         <= '0;
          ram_address <= BASE_ADDR;
        end
        CAPTURE: begin
          cell_data  <= ram_data;
          cell_row   <= row;
          cell_col   <= col;
          cell_last  <= at_last;
          cell_valid <= 1'b1;
        end
        PRESENT: if (accept) begin
          cell_valid <= 1'b0;
          cell_last  <= 1'b0;
          if (!cell_last) begin
            ram_address <= ram_address + 32'd4;
            if (col == LAST_COL) begin
              col <= '0;
              row <= row + 4'd1;
            end else begin
              col <= col + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
